ritc_bit_control_decoder: RTL and testbench

- Receive-side decoder for the serial RITC bit-control stream.
- Watches the single-wire control line for a start bit, then deserializes the 70-bit frame that follows.
- Decodes the bitslip flag, the 5-bit delay, the one-hot channel select and the one-hot bit select back into binary addresses.
- Presents each decoded command with a one-cycle valid strobe. Used as the RITC-side model in loopback and verification, and as a monitor on the control wire.

---
 rtl/ritc_ctrl_pkg.sv | 47 ++++
 rtl/ritc_onehot_decode.sv | 33 +++
 rtl/ritc_bit_control_decoder.sv | 134 +++++++++++++
 tb/tb_ritc_bit_control_decoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ritc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ritc_ctrl_pkg
// Shared constants and types for the RITC bit-control stream.
// Frame layout in the receive shifter (first-received data bit at index 0):
//   [0]      bitslip
//   [1..5]   delay[4] .. delay[0]
//   [6..37]  channel select bit 31 .. bit 0
//   [38..69] bit select bit 31 .. bit 0
// ----------------------------------------------------------------------------
package ritc_ctrl_pkg;

    localparam int unsigned FRAME_BITS  = 70;
    localparam int unsigned BITSLIP_POS = 0;
    localparam int unsigned DELAY_MSB   = 1;
    localparam int unsigned CHAN_MSB    = 6;
    localparam int unsigned BIT_MSB     = 38;

    localparam int unsigned DELAY_W = 5;
    localparam int unsigned FIELD_W = 32;

    localparam logic [3:0] BROADCAST_BIT_ADDR = 4'd13;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Fields arrive MSB first, so they land bit-reversed in the shifter.
    function automatic logic [FIELD_W-1:0] rev_field(input logic [FIELD_W-1:0] v);
        logic [FIELD_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < FIELD_W; i++) begin
            r[i] = v[FIELD_W-1-i];
        end
        return r;
    endfunction

    function automatic logic [DELAY_W-1:0] rev_delay(input logic [DELAY_W-1:0] v);
        logic [DELAY_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DELAY_W; i++) begin
            r[i] = v[DELAY_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ritc_onehot_decode.sv
// ----------------------------------------------------------------------------
// ritc_onehot_decode
// Combinational decode of a 32-bit one-hot select field.
//   field_i : select field (bit n set selects index n)
//   idx_o   : lowest set index (0 when the field is empty)
//   zero_o  : no bit set
//   multi_o : two or more bits set
// ----------------------------------------------------------------------------
module ritc_onehot_decode (
    input  logic [31:0] field_i,
    output logic [4:0]  idx_o,
    output logic        zero_o,
    output logic        multi_o
);

    logic w_found;

    always_comb begin
        idx_o   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (field_i[i] && !w_found) begin
                idx_o   = 5'(i);
                w_found = 1'b1;
            end
        end
    end

    assign zero_o  = ~|field_i;
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    assign multi_o = |(field_i & (field_i - 32'd1));

endmodule

// File: rtl/ritc_bit_control_decoder.sv
// ----------------------------------------------------------------------------
// ritc_bit_control_decoder
// Receive-side decoder for the serial RITC bit-control stream. Waits for a
// start bit on ctrl_i, deserialises the FRAME_BITS data bits that follow,
// and presents the decoded command with a one-cycle valid_o strobe.
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   ctrl_i       serial control line, idle low
//   valid_o      one-cycle strobe, decoded fields valid
//   bitslip_o    frame bitslip bit
//   delay_o      decoded delay
//   chan_addr_o  decoded channel index
//   bit_addr_o   decoded bit index (13 when broadcast)
//   broadcast_o  bit field held two or more ones
//   err_o        frame malformed (qualified by valid_o)
//   busy_o       frame being received
// ----------------------------------------------------------------------------
module ritc_bit_control_decoder #(
    parameter int unsigned FRAME_BITS = ritc_ctrl_pkg::FRAME_BITS
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ctrl_i,
    output logic       valid_o,
    output logic       bitslip_o,
    output logic [4:0] delay_o,
    output logic [2:0] chan_addr_o,
    output logic [3:0] bit_addr_o,
    output logic       broadcast_o,
    output logic       err_o,
    output logic       busy_o
);

    import ritc_ctrl_pkg::*;

    state_t                r_state;
    logic [6:0]            r_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] r_hold;
    logic                  r_hold_vld;

    logic [FRAME_BITS-1:0] w_shift_next;
    logic [FIELD_W-1:0]    w_chan_field;
    logic [FIELD_W-1:0]    w_bit_field;
    logic [DELAY_W-1:0]    w_delay;
    logic [4:0]            w_ch_idx;
    logic                  w_ch_zero;
    logic                  w_ch_multi;
    logic [4:0]            w_b_idx;
    logic                  w_b_zero;
    logic                  w_b_multi;
    logic                  w_chan_err;
    logic                  w_bit_err;
    logic [3:0]            w_bit_addr;

    assign w_shift_next = {ctrl_i, r_shift[FRAME_BITS-1:1]};

    assign w_delay      = rev_delay(r_hold[DELAY_MSB +: DELAY_W]);
    assign w_chan_field = rev_field(r_hold[CHAN_MSB +: FIELD_W]);
    assign w_bit_field  = rev_field(r_hold[BIT_MSB +: FIELD_W]);

    ritc_onehot_decode u_chan_dec (
        .field_i (w_chan_field),
        .idx_o   (w_ch_idx),
        .zero_o  (w_ch_zero),
        .multi_o (w_ch_multi)
    );

    ritc_onehot_decode u_bit_dec (
        .field_i (w_bit_field),
        .idx_o   (w_b_idx),
        .zero_o  (w_b_zero),
        .multi_o (w_b_multi)
    );

    always_comb begin
        w_chan_err = w_ch_zero | w_ch_multi | (w_ch_idx > 5'd7);
        w_bit_err  = w_b_zero | (!w_b_multi && (w_b_idx > 5'd15));
        w_bit_addr = w_b_multi ? BROADCAST_BIT_ADDR : w_b_idx[3:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_vld  <= 1'b0;
            valid_o     <= 1'b0;
            bitslip_o   <= 1'b0;
            delay_o     <= '0;
            chan_addr_o <= '0;
            bit_addr_o  <= '0;
            broadcast_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            valid_o    <= r_hold_vld;
            r_hold_vld <= 1'b0;

            // Decode runs off the hold register one cycle after it loads,
            // leaving the shifter free for an immediately following frame.
            if (r_hold_vld) begin
                bitslip_o   <= r_hold[BITSLIP_POS];
                delay_o     <= w_delay;
                chan_addr_o <= w_ch_idx[2:0];
                bit_addr_o  <= w_bit_addr;
                broadcast_o <= w_b_multi;
                err_o       <= w_chan_err | w_bit_err;
            end

            case (r_state)
                ST_IDLE: begin
                    if (ctrl_i) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + 7'd1;
                    if (r_cnt == 7'(FRAME_BITS - 1)) begin
                        r_hold     <= w_shift_next;
                        r_hold_vld <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_ritc_bit_control_decoder.sv
// ----------------------------------------------------------------------------
// tb_ritc_bit_control_decoder
// Directed self-checking bench for ritc_bit_control_decoder. Each sent frame
// pushes its expected decode (and the cycle valid_o must appear on) to a
// queue; a monitor pops and compares on every valid_o strobe.
// ----------------------------------------------------------------------------
module tb_ritc_bit_control_decoder;

    logic       clk;
    logic       rst;
    logic       ctrl;
    logic       valid;
    logic       bitslip;
    logic [4:0] delay;
    logic [2:0] chan_addr;
    logic [3:0] bit_addr;
    logic       broadcast;
    logic       err;
    logic       busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    typedef struct {
        logic        bs;
        logic [4:0]  d;
        logic [2:0]  ch;
        logic [3:0]  b;
        logic        bc;
        logic        er;
        int unsigned at;
    } exp_t;

    exp_t sb[$];

    ritc_bit_control_decoder #(.FRAME_BITS(70)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ctrl_i      (ctrl),
        .valid_o     (valid),
        .bitslip_o   (bitslip),
        .delay_o     (delay),
        .chan_addr_o (chan_addr),
        .bit_addr_o  (bit_addr),
        .broadcast_o (broadcast),
        .err_o       (err),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_bitslip"}, 32'(bitslip), 32'd0);
        chk({tag, "_delay"}, 32'(delay), 32'd0);
        chk({tag, "_chan"}, 32'(chan_addr), 32'd0);
        chk({tag, "_bit"}, 32'(bit_addr), 32'd0);
        chk({tag, "_bcast"}, 32'(broadcast), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Drives start bit + 70 data bits; returns right after edge E70.
    task automatic send(input logic bs, input logic [4:0] d,
                        input logic [31:0] chf, input logic [31:0] bf,
                        input logic [2:0] ech, input logic [3:0] eb,
                        input logic ebc, input logic eer);
        exp_t e;
        logic b;
        ctrl = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_start", 32'(busy), 32'd1);
        e.bs = bs; e.d = d; e.ch = ech; e.b = eb; e.bc = ebc; e.er = eer;
        e.at = cyc + 71;
        sb.push_back(e);
        for (int k = 1; k <= 70; k++) begin
            if (k == 1)       b = bs;
            else if (k <= 6)  b = d[6-k];
            else if (k <= 38) b = chf[38-k];
            else              b = bf[70-k];
            ctrl = b;
            @(posedge clk); #1;
        end
        ctrl = 1'b0;
        chk("busy_after_e70", 32'(busy), 32'd0);
    endtask

    // Scoreboard monitor: every valid_o strobe must match the queue head.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_cycle", cyc, e.at);
                chk("bitslip", 32'(bitslip), 32'(e.bs));
                chk("delay", 32'(delay), 32'(e.d));
                chk("err", 32'(err), 32'(e.er));
                chk("broadcast", 32'(broadcast), 32'(e.bc));
                if (!e.er) begin
                    chk("chan_addr", 32'(chan_addr), 32'(e.ch));
                    chk("bit_addr", 32'(bit_addr), 32'(e.b));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        ctrl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame: delay 21, channel 5, bit 9
        send(1'b0, 5'd21, 32'h1 << 5, 32'h1 << 9, 3'd5, 4'd9, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Bitslip with broadcast bit field
        send(1'b1, 5'd10, 32'h1, 32'hFFFF_FFFF, 3'd0, 4'd13, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back frames, second start bit sampled at E71
        send(1'b0, 5'd3, 32'h1 << 7, 32'h1 << 15, 3'd7, 4'd15, 1'b0, 1'b0);
        send(1'b1, 5'd31, 32'h1 << 1, 32'h1, 3'd1, 4'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Malformed frames
        send(1'b0, 5'd1, 32'h0, 32'h1 << 2, 3'd0, 4'd2, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        send(1'b0, 5'd2, 32'h1 << 12, 32'h1 << 2, 3'd4, 4'd2, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        send(1'b0, 5'd4, 32'h1 << 2, 32'h1 << 20, 3'd2, 4'd4, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        send(1'b0, 5'd8, 32'h1 << 2, 32'h0, 3'd2, 4'd0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Leave nonzero outputs behind so the reset clear is observable
        send(1'b1, 5'd19, 32'h1 << 6, 32'h1 << 11, 3'd6, 4'd11, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Reset at E35 of a frame, with a 1 on the line at that edge
        ctrl = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 34; k++) begin
            ctrl = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        rst  = 1'b1;
        ctrl = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("mid_frame_reset");
        rst  = 1'b0;
        ctrl = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("no_valid_after_reset_frame", 32'(sb.size()), 32'd0);

        // Clean frame after reset
        send(1'b0, 5'd7, 32'h1 << 3, 32'h1 << 4, 3'd3, 4'd4, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Long idle line
        ctrl = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_valid", 32'(valid), 32'd0);
        end

        @(posedge clk); #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
